if_prefetch_buffer: RTL and testbench
=====================================

// Module: if_prefetch_buffer
// PURPOSE
//  Instruction-fetch front end. Issues sequential fetches to a variable-latency instruction
//  memory (req/ack) and buffers the results in a DEPTH-entry FIFO of {PC+4, instr}.
//  The FIFO feeds the IF/ID pipe register via a valid/ready handshake.
//  A branch redirect from the MEM stage flushes the queue and restarts fetch at the target.
// PARAMETERS
//  DEPTH     4      FIFO entries; power of 2, >=2
//  RESET_PC  32'h0  first fetch address after reset
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_n          in   1   asynchronous reset, active low
//  imem_req_o     out  1   fetch request; held high until ack
//  imem_addr_o    out  32  fetch address; stable while imem_req_o=1
//  imem_ack_i     in   1   data valid this cycle; only sampled while imem_req_o=1
//  imem_instr_i   in   32  fetched instruction, valid with imem_ack_i
//  redirect_i     in   1   taken branch: flush and refetch
//  redirect_pc_i  in   32  branch target
//  id_valid_o     out  1   FIFO head valid (count!=0)
//  id_ready_i     in   1   IF/ID accepts head this cycle
//  id_instr_o     out  32  head instruction; 0 when empty
//  id_pc_add4_o   out  32  head PC+4; 0 when empty
//  count_o        out  log2(DEPTH)+1  entries held
// BEHAVIOUR
//  Reset (async): state=IDLE, fetch_pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC,
//    FIFO pointers=0, count_o=0, id_valid_o=0. Any outstanding fetch is abandoned.
//  FSM (registered; imem_req_o=1 in BUSY and FLUSH):
//   IDLE : if count_next<DEPTH -> BUSY, imem_addr_o<=fetch_pc.
//   BUSY : on ack -> push {fetch_pc+4, imem_instr_i}, fetch_pc+=4;
//          if count_next<DEPTH stay BUSY with imem_addr_o<=fetch_pc+4 (back-to-back), else IDLE.
//   FLUSH: on ack -> discard data, go IDLE. No push.
//   count_next = count + push - pop.
//  Handshake:
//   - pop when id_valid_o & id_ready_i.
//   - head data is combinational from the FIFO read pointer.
//   - Ack may arrive in the same cycle req rises (combinational IMEM: tie imem_ack_i=1).
//  Redirect (priority over push and pop in the same cycle):
//   - FIFO cleared (count=0, pointers reset); fetch_pc<=redirect_pc_i.
//   - IDLE -> IDLE. BUSY with ack -> IDLE; the acked data is dropped.
//   - BUSY without ack -> FLUSH, holding req and addr.
//   - FLUSH + redirect -> stays FLUSH with the new fetch_pc.
//   - id_valid_o=0 in the cycle after a redirect.
//  Invariants:
//   - At most one fetch is outstanding.
//   - A request is issued only if a slot is free, so an ack never sees a full FIFO.
//   - Push and pop in the same cycle: count unchanged, pointers wrap mod DEPTH.
//  Arithmetic: PC+4 is 32-bit unsigned and wraps at 2^32; no alignment check.
//  Latency:
//   - First request is high 1 cycle after reset release.
//   - With imem_ack_i=1, first id_valid_o 2 cycles after reset release.
//   - Steady state: 1 instr/cycle while id_ready_i=1.
// TESTING
//  T1 imem_ack_i tied 1, id_ready_i=1 -> id_pc_add4_o 4,8,12,... one per cycle; count_o<=1.
//  T2 id_ready_i=0, ack tied 1 -> exactly DEPTH pushes; then IDLE with req=0, count_o=DEPTH.
//     Raise ready -> queue drains in order and fetch resumes at RESET_PC+4*DEPTH.
//  T3 ack 3 cycles after each req -> imem_addr_o stable while req=1; no duplicate or lost entries.
//  T4 redirect_pc_i=0x100 during BUSY, ack 2 cycles later -> that ack's data is discarded.
//     Next request is to addr 0x100; first valid head has id_pc_add4_o=0x104.
//  T5 redirect with ack and pop in the same cycle -> count_o=0 next cycle and the acked
//     instr never appears. Back-to-back redirects in FLUSH -> the last target wins.
//  T6 rst_n low mid-BUSY (asynchronous, between edges) -> all outputs at reset values
//     immediately; a late ack is ignored.

Source files
------------

// File: rtl/if_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// if_prefetch_buffer
//   Instruction-fetch front end. Issues sequential fetches to a variable-latency
//   instruction memory (req/ack) and buffers the results in a DEPTH-entry FIFO
//   of {PC+4, instr}. The FIFO head feeds the IF/ID pipe register through a
//   valid/ready handshake. A branch redirect flushes the queue and restarts
//   fetch at the branch target; a fetch that is still in flight at that moment
//   is completed on the memory side but its data is thrown away.
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_n          in   asynchronous reset, active low
//   imem_req_o     out  fetch request, held high until ack
//   imem_addr_o    out  fetch address, stable while imem_req_o=1
//   imem_ack_i     in   instruction valid this cycle (only honoured while req=1)
//   imem_instr_i   in   fetched instruction, valid with imem_ack_i
//   redirect_i     in   taken branch: flush and refetch
//   redirect_pc_i  in   branch target
//   id_valid_o     out  FIFO head valid
//   id_ready_i     in   IF/ID accepts the head this cycle
//   id_instr_o     out  head instruction, 0 when empty
//   id_pc_add4_o   out  head PC+4, 0 when empty
//   count_o        out  number of entries held
// -----------------------------------------------------------------------------
module if_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_instr_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [31:0]              id_instr_o,
    output logic [31:0]              id_pc_add4_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e            state_r;
    logic              req_r;
    logic [31:0]       addr_r;
    logic [31:0]       fetch_pc_r;

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [31:0]       mem_instr_r [DEPTH];
    logic [31:0]       mem_pc4_r   [DEPTH];

    logic              ack_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [31:0]       pc_plus4_s;
    logic              has_room_s;
    logic [31:0]       head_instr_s;
    logic [31:0]       head_pc4_s;

    // The ack only counts while a request is actually outstanding; only BUSY
    // data is kept, FLUSH data belongs to a fetch made obsolete by a redirect.
    assign ack_s        = req_r & imem_ack_i;
    assign push_s       = (state_r == ST_BUSY) & ack_s & ~redirect_i;
    assign pop_s        = (count_r != {CNT_W{1'b0}}) & id_ready_i & ~redirect_i;
    assign count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    assign pc_plus4_s   = fetch_pc_r + 32'd4;
    // A new request only goes out when the slot it will fill is guaranteed,
    // so an ack can never arrive against a full FIFO.
    assign has_room_s   = (count_next_s < DEPTH_C);

    // Fetch sequencer: request/address are registered and change only here.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            req_r      <= 1'b0;
            addr_r     <= RESET_PC;
            fetch_pc_r <= RESET_PC;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_i) begin
                        fetch_pc_r <= redirect_pc_i;
                    end else if (has_room_s) begin
                        state_r <= ST_BUSY;
                        req_r   <= 1'b1;
                        addr_r  <= fetch_pc_r;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (redirect_i) begin
                        fetch_pc_r <= redirect_pc_i;
                        if (ack_s) begin
                            state_r <= ST_IDLE;
                            req_r   <= 1'b0;
                        end else begin
                            // Keep req/addr steady until the stale fetch completes.
                            state_r <= ST_FLUSH;
                        end
                    end else if (ack_s) begin
                        fetch_pc_r <= pc_plus4_s;
                        if (has_room_s) begin
                            addr_r <= pc_plus4_s;
                        end else begin
                            state_r <= ST_IDLE;
                            req_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_FLUSH: begin
                    if (redirect_i) begin
                        fetch_pc_r <= redirect_pc_i;
                    end else begin
                        fetch_pc_r <= fetch_pc_r;
                    end
                    if (ack_s) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue ahead of any push or pop.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (redirect_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            count_r <= count_next_s;
        end
    end

    // FIFO storage; contents are never observed while the entry is unoccupied.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_instr_r[wr_ptr_r] <= imem_instr_i;
            mem_pc4_r[wr_ptr_r]   <= pc_plus4_s;
        end
    end

    // Head presentation, forced to zero when the queue is empty.
    always_comb begin
        head_instr_s = 32'h0000_0000;
        head_pc4_s   = 32'h0000_0000;
        if (count_r != {CNT_W{1'b0}}) begin
            head_instr_s = mem_instr_r[rd_ptr_r];
            head_pc4_s   = mem_pc4_r[rd_ptr_r];
        end else begin
            head_instr_s = 32'h0000_0000;
            head_pc4_s   = 32'h0000_0000;
        end
    end

    assign imem_req_o   = req_r;
    assign imem_addr_o  = addr_r;
    assign id_valid_o   = (count_r != {CNT_W{1'b0}});
    assign id_instr_o   = head_instr_s;
    assign id_pc_add4_o = head_pc4_s;
    assign count_o      = count_r;

endmodule

// File: tb/tb_if_prefetch_buffer.sv
module tb_if_prefetch_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_instr_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_add4_o;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;

    if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_instr_i(imem_instr_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_instr_o(id_instr_o), .id_pc_add4_o(id_pc_add4_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model: one outstanding fetch + a queue ----------
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    entry_t      m_q[$];
    bit          m_busy;     // a fetch is outstanding
    bit          m_stale;    // outstanding fetch was overtaken by a redirect
    logic [31:0] m_addr;
    logic [31:0] m_pc;       // next sequential fetch address

    task automatic model_reset();
        m_q.delete();
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_addr  = 32'h0;
        m_pc    = 32'h0;
    endtask

    task automatic model_edge(input logic ack, input logic ready, input logic rdr,
                              input logic [31:0] rpc, input logic [31:0] instr);
        bit pop;
        bit done;
        pop  = (m_q.size() != 0) && ready;
        done = m_busy && ack;
        if (rdr) begin
            m_q.delete();
            m_pc = rpc;
            if (m_busy && !done) begin
                m_stale = 1'b1;
            end else begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (done) begin
                if (!m_stale) begin
                    m_q.push_back('{pc4: m_pc + 32'd4, instr: instr});
                    m_pc = m_pc + 32'd4;
                end
                if (!m_stale && m_q.size() < DEPTH) begin
                    m_addr = m_pc;
                end else begin
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end
            end else if (!m_busy) begin
                if (m_q.size() < DEPTH) begin
                    m_busy = 1'b1;
                    m_addr = m_pc;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req_o), 32'(m_busy));
        if (m_busy) chk({tag, "_addr"}, imem_addr_o, m_addr);
        chk({tag, "_valid"}, 32'(id_valid_o), 32'(m_q.size() != 0));
        chk({tag, "_count"}, 32'(count_o), 32'(m_q.size()));
        chk({tag, "_pc4"}, id_pc_add4_o, (m_q.size() != 0) ? m_q[0].pc4 : 32'h0);
        chk({tag, "_instr"}, id_instr_o, (m_q.size() != 0) ? m_q[0].instr : 32'h0);
    endtask

    // Drive one cycle's inputs (just after a falling edge), advance the model,
    // and return at the next falling edge.
    task automatic cyc(input logic ack, input logic ready, input logic rdr,
                       input logic [31:0] rpc, input logic [31:0] instr);
        imem_ack_i    = ack;
        id_ready_i    = ready;
        redirect_i    = rdr;
        redirect_pc_i = rpc;
        imem_instr_i  = instr;
        model_edge(ack, ready, rdr, rpc, instr);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ack_i = 1'b0; id_ready_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'h0; imem_instr_i = 32'h0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table (fill, stall, drain, redirect) ------
    typedef struct {
        logic        ack;
        logic        ready;
        logic        rdr;
        logic [31:0] rpc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc4;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        a;
        logic [31:0] held;
        int          wcnt;

        //            ack   rdy   rdr   rpc           req   addr          vld   pc4           cnt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h0,      3'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h0,      1'b0, 32'h0,      3'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h4,      1'b1, 32'h4,      3'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h8,      1'b1, 32'h4,      3'd2};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'hC,      1'b1, 32'h4,      3'd3};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h4,      3'd4};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'h4,      3'd4};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h10,     1'b1, 32'h8,      3'd3};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h14,     1'b1, 32'hC,      3'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h18,     1'b1, 32'h10,     3'd3};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1C,     1'b1, 32'h14,     3'd3};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1C,     1'b1, 32'h18,     3'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b1, 32'h1C,     1'b1, 32'h1C,     3'd1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h1C,     1'b0, 32'h0,      3'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h100,    1'b1, 32'h20,     1'b1, 32'h20,     3'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h20,     1'b0, 32'h0,      3'd0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h20,     1'b0, 32'h0,      3'd0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h0,      3'd0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h100,    1'b0, 32'h0,      3'd0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 32'h104,    1'b1, 32'h104,    3'd1};

        // Reset state while rst_n is held low.
        #3;
        chk("rst_req", 32'(imem_req_o), 32'h0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", 32'(id_valid_o), 32'h0);
        chk("rst_count", 32'(count_o), 32'h0);

        // ---- table: fill to DEPTH, stall, drain, resume at 16, redirect mid-BUSY ----
        do_reset();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("tbl%0d_req", i), 32'(imem_req_o), 32'(tbl[i].exp_req));
            if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(id_valid_o), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_pc4", i), id_pc_add4_o, tbl[i].exp_pc4);
            chk($sformatf("tbl%0d_count", i), 32'(count_o), 32'(tbl[i].exp_cnt));
            cyc(tbl[i].ack, tbl[i].ready, tbl[i].rdr, tbl[i].rpc, 32'h1000_0000 + 32'(i));
        end

        // ---- T1: ack tied high, ready high: one instruction per cycle ----
        do_reset();
        for (int k = 0; k < 20; k++) begin
            check_outputs("t1");
            if (k >= 2) chk("t1_pc4_seq", id_pc_add4_o, 32'(4 * (k - 1)));
            chk("t1_count_le1", 32'(count_o <= 3'd1), 32'h1);
            cyc(1'b1, 1'b1, 1'b0, 32'h0, $urandom());
        end

        // ---- T3: ack three cycles after each request, random ready ----
        do_reset();
        wcnt = 0;
        held = 32'h0;
        for (int k = 0; k < 80; k++) begin
            check_outputs("t3");
            if (imem_req_o) begin
                if (wcnt != 0) chk("t3_addr_stable", imem_addr_o, held);
                else held = imem_addr_o;
                a = (wcnt == 2);
                wcnt = a ? 0 : wcnt + 1;
            end else begin
                a = 1'b0;
                wcnt = 0;
            end
            cyc(a, 1'($urandom_range(0, 1)), 1'b0, 32'h0, $urandom());
        end

        // ---- T5: redirect with ack and pop together, then chained redirects ----
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check_outputs("t5_fill");
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h2000_0000 + 32'(k));
        end
        check_outputs("t5_pre");
        cyc(1'b1, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
        chk("t5_count_cleared", 32'(count_o), 32'h0);
        chk("t5_valid_low", 32'(id_valid_o), 32'h0);
        chk("t5_req_low", 32'(imem_req_o), 32'h0);
        for (int k = 0; k < 6; k++) begin
            check_outputs("t5_run");
            if (id_valid_o) chk("t5_dropped_instr_absent", 32'(id_instr_o == 32'hDEAD_BEEF), 32'h0);
            if (k == 2) chk("t5_first_pc4", id_pc_add4_o, 32'h204);
            cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h5000_0000 + 32'(k));
        end
        check_outputs("t5_b2b0");
        cyc(1'b0, 1'b1, 1'b1, 32'h300, 32'h0);
        check_outputs("t5_b2b1");
        cyc(1'b0, 1'b1, 1'b1, 32'h400, 32'h0);
        check_outputs("t5_b2b2");
        cyc(1'b0, 1'b1, 1'b1, 32'h500, 32'h0);
        check_outputs("t5_b2b3");
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'hBAD0_0001);
        check_outputs("t5_b2b4");
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("t5_last_target_req", 32'(imem_req_o), 32'h1);
        chk("t5_last_target_addr", imem_addr_o, 32'h500);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h6000_0000);
        chk("t5_last_target_pc4", id_pc_add4_o, 32'h504);
        check_outputs("t5_end");

        // ---- T6: asynchronous reset between edges while BUSY ----
        do_reset();
        check_outputs("t6_a");
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h7000_0000);
        check_outputs("t6_b");
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_req", 32'(imem_req_o), 32'h0);
        chk("t6_addr", imem_addr_o, 32'h0);
        chk("t6_valid", 32'(id_valid_o), 32'h0);
        chk("t6_count", 32'(count_o), 32'h0);
        chk("t6_instr", id_instr_o, 32'h0);
        chk("t6_pc4", id_pc_add4_o, 32'h0);
        imem_ack_i = 1'b1;
        @(negedge clk_i);
        rst_n = 1'b1;
        model_reset();
        check_outputs("t6_rel");
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'hBAD0_0002);
        chk("t6_late_ack_ignored", 32'(count_o), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check_outputs("t6_run");
            cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h7100_0000 + 32'(k));
        end

        // ---- randomized run against the model (includes wrap at 2^32) ----
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            logic        r_ack;
            logic        r_rdy;
            logic        r_rdr;
            logic [31:0] r_pc;
            check_outputs("rnd");
            r_ack = ($urandom_range(0, 99) < 60);
            r_rdy = ($urandom_range(0, 99) < 70);
            r_rdr = ($urandom_range(0, 99) < 4);
            r_pc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom();
            cyc(r_ack, r_rdy, r_rdr, r_pc, $urandom());
        end
        check_outputs("rnd_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
